// File: rtl/radar_sync_pkg.sv
// Shared definitions for the radar sync logic.
//   state_e        : CPI sequencer states (IDLE waits for trigger, RUN counts PRTs)
//   MODE_BIN       : switch bank counts in binary once per PRT
//   MODE_ONEHOT    : switch bank rotates a single set bit once per PRT
//   switch_rst_pat : switch bank reset pattern for a given mode (8 bits, caller slices)
package radar_sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MODE_BIN    = 0;
  localparam int MODE_ONEHOT = 1;

  function automatic logic [7:0] switch_rst_pat(input int mode);
    return (mode == MODE_ONEHOT) ? 8'h01 : 8'h00;
  endfunction

endpackage

// File: rtl/pmt_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk_i   : sampling clock
//   rst_i   : synchronous active-high reset, clears all flops
//   async_i : asynchronous input
//   edge_o  : high for one cycle after a synchronised 0->1 transition
// Since the flops clear to 0, an input held high across reset yields one
// edge after reset is released.
module pmt_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;  // s2 delayed by one cycle, reference for the edge compare

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/prt_switch_seq.sv
// PRT switch sequencer. After a synchronised rising edge on pmt, runs
// CPILENGTH pulse-repetition intervals of PRTWIDTH cycles and steps the
// NCH-bit switch bank DELAY cycles before the end of every PRT.
//   sysclk    : system clock
//   btn[0]    : synchronous active-high reset
//   pmt       : asynchronous trigger
//   switch    : switch bank drive (registered)
//   cpi       : index of the current PRT within the CPI
//   busy      : high while a CPI is running
//   prt_start : one-cycle pulse in the first cycle of each PRT
//   cpi_done  : one-cycle pulse in the cycle after the last PRT completes
//   state_dbg : current sequencer state
// Handshake: none; pmt is a free-running trigger and all outputs are
// status strobes/levels with no back-pressure.
module prt_switch_seq
  import radar_sync_pkg::*;
#(
  parameter int PRTWIDTH  = 2400,
  parameter int DELAY     = 1,
  parameter int CPILENGTH = 100,
  parameter int NCH       = 2,
  parameter int MODE      = 0,
  parameter int PHASE_CLR = 1,
  parameter int CNT_W     = 12,
  parameter int CPI_W     = 8
) (
  input  logic             sysclk,
  input  logic [0:0]       btn,
  input  logic             pmt,
  output logic [NCH-1:0]   switch,
  output logic [CPI_W-1:0] cpi,
  output logic             busy,
  output logic             prt_start,
  output logic             cpi_done,
  output state_e           state_dbg
);

  if (CNT_W < 31 && (1 << CNT_W) < PRTWIDTH) begin : g_bad_cnt_w
    $error("CNT_W too small for PRTWIDTH");
  end
  if (CPI_W < 31 && (1 << CPI_W) < CPILENGTH) begin : g_bad_cpi_w
    $error("CPI_W too small for CPILENGTH");
  end
  if (MODE == MODE_ONEHOT && NCH < 2) begin : g_bad_nch
    $error("one-hot mode needs NCH >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRTWIDTH - 1);
  localparam logic [CNT_W-1:0] SW_EVT   = CNT_W'(PRTWIDTH - 1 - DELAY);
  localparam logic [CPI_W-1:0] CPI_LAST = CPI_W'(CPILENGTH - 1);
  localparam logic [7:0]       RST_PAT8 = switch_rst_pat(MODE);
  localparam logic [NCH-1:0]   RST_PAT  = RST_PAT8[NCH-1:0];

  logic rst;
  logic pmt_edge;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CPI_W-1:0] cpi_q, cpi_d;
  logic [NCH-1:0]   sw_q, sw_d;
  logic             busy_q, busy_d;
  logic             prt_start_q, prt_start_d;
  logic             cpi_done_q, cpi_done_d;
  logic             wrap;
  logic             last_prt;

  assign rst = btn[0];

  pmt_edge_sync u_pmt_sync (
    .clk_i   (sysclk),
    .rst_i   (rst),
    .async_i (pmt),
    .edge_o  (pmt_edge)
  );

  assign wrap     = (count_q == CNT_LAST);
  assign last_prt = (cpi_q == CPI_LAST);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cpi_d       = cpi_q;
    sw_d        = sw_q;
    busy_d      = busy_q;
    prt_start_d = 1'b0;
    cpi_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pmt_edge) begin
          state_d     = RUN;
          count_d     = '0;
          cpi_d       = '0;
          busy_d      = 1'b1;
          prt_start_d = 1'b1;
        end
      end
      RUN: begin
        count_d = wrap ? '0 : count_q + 1'b1;
        if (count_q == SW_EVT) begin
          if (MODE == MODE_ONEHOT) sw_d = (sw_q << 1) | (sw_q >> (NCH - 1));
          else                     sw_d = sw_q + NCH'(1);
        end
        if (wrap) begin
          prt_start_d = 1'b1;
          cpi_d       = cpi_q + 1'b1;
          if (last_prt) begin
            cpi_d      = '0;
            cpi_done_d = 1'b1;
            // Clear wins over a coincident switch event (DELAY = 0).
            if (PHASE_CLR != 0) sw_d = RST_PAT;
            // A trigger landing exactly on the final cycle chains the next
            // CPI with no idle gap; otherwise drop back to IDLE.
            if (!pmt_edge) begin
              state_d     = IDLE;
              busy_d      = 1'b0;
              prt_start_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      cpi_q       <= '0;
      sw_q        <= RST_PAT;
      busy_q      <= 1'b0;
      prt_start_q <= 1'b0;
      cpi_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cpi_q       <= cpi_d;
      sw_q        <= sw_d;
      busy_q      <= busy_d;
      prt_start_q <= prt_start_d;
      cpi_done_q  <= cpi_done_d;
    end
  end

  assign switch    = sw_q;
  assign cpi       = cpi_q;
  assign busy      = busy_q;
  assign prt_start = prt_start_q;
  assign cpi_done  = cpi_done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_prt_switch_seq.sv
// Bench for prt_switch_seq: two instances (binary and one-hot mode) share
// the same reset and trigger. Expected output vectors
// {busy, prt_start, cpi_done, cpi[7:0], switch[1:0]} are queued per cycle
// when a trigger is driven and compared on the falling edge.
module tb_prt_switch_seq;
  import radar_sync_pkg::*;

  localparam int PRTW = 16;
  localparam int DLY  = 2;
  localparam int CPIL = 3;
  localparam int W    = 13;

  logic       clk = 1'b0;
  logic [0:0] btn;
  logic       pmt;
  int         cyc = 0;

  logic [1:0] sw0, sw1;
  logic [7:0] cpi0, cpi1;
  logic       busy0, busy1, ps0, ps1, cd0, cd1;
  state_e     st0, st1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  prt_switch_seq #(
    .PRTWIDTH(PRTW), .DELAY(DLY), .CPILENGTH(CPIL), .NCH(2),
    .MODE(0), .PHASE_CLR(1), .CNT_W(4), .CPI_W(8)
  ) dut0 (
    .sysclk(clk), .btn(btn), .pmt(pmt), .switch(sw0), .cpi(cpi0),
    .busy(busy0), .prt_start(ps0), .cpi_done(cd0), .state_dbg(st0)
  );

  prt_switch_seq #(
    .PRTWIDTH(PRTW), .DELAY(DLY), .CPILENGTH(CPIL), .NCH(2),
    .MODE(1), .PHASE_CLR(1), .CNT_W(4), .CPI_W(8)
  ) dut1 (
    .sysclk(clk), .btn(btn), .pmt(pmt), .switch(sw1), .cpi(cpi1),
    .busy(busy1), .prt_start(ps1), .cpi_done(cd1), .state_dbg(st1)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference values ----------------
  function automatic logic [1:0] rst_sw(input int mode);
    return (mode == 1) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [W-1:0] idle_vec(input int mode);
    return {3'b000, 8'd0, rst_sw(mode)};
  endfunction

  // k = cycles since the RUN entry edge E; k == CPIL*PRTW is the cpi_done cycle.
  function automatic logic [W-1:0] exp_vec(input int k, input int mode);
    int         n;
    logic [1:0] sw;
    if (k >= CPIL * PRTW) return {3'b001, 8'd0, rst_sw(mode)};
    n  = (k + DLY) / PRTW;  // switch events already taken
    sw = (mode == 0) ? 2'(n) : (((n % 2) == 1) ? 2'b10 : 2'b01);
    return {1'b1, ((k % PRTW) == 0), 1'b0, 8'(k / PRTW), sw};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push_vec(input int c, input logic [W-1:0] v0, input logic [W-1:0] v1);
    exp_cyc_q.push_back(c);
    exp_q0.push_back(v0);
    exp_q1.push_back(v1);
  endtask

  task automatic push_cpi(input int e, input int k_lo, input int k_hi);
    for (int k = k_lo; k <= k_hi; k++) push_vec(e + k, exp_vec(k, 0), exp_vec(k, 1));
  endtask

  task automatic push_idle(input int c_lo, input int c_hi);
    for (int c = c_lo; c <= c_hi; c++) push_vec(c, idle_vec(0), idle_vec(1));
  endtask

  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      check_eq($sformatf("bin cyc %0d", cyc), {busy0, ps0, cd0, cpi0, sw0}, exp_q0.pop_front());
      check_eq($sformatf("onehot cyc %0d", cyc), {busy1, ps1, cd1, cpi1, sw1}, exp_q1.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  end

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pmt is first sampled at the next edge N; RUN is entered at E = N + 2.
  task automatic pmt_rise(output int e);
    e   = cyc + 3;
    pmt = 1'b1;
  endtask

  task automatic pmt_hold_drop(input int n);
    repeat (n) @(posedge clk);
    #1;
    pmt = 1'b0;
  endtask

  task automatic short_pulse;
    pmt = 1'b1;
    pmt_hold_drop(2);
  endtask

  int e;

  initial begin
    btn = 1'b1;
    pmt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    btn = 1'b0;
    check_eq("reset bin", {busy0, ps0, cd0, cpi0, sw0}, idle_vec(0));
    check_eq("reset onehot", {busy1, ps1, cd1, cpi1, sw1}, idle_vec(1));

    // nominal CPI
    wait_until(cyc + 6);
    pmt_rise(e);
    push_cpi(e, 0, CPIL * PRTW);
    push_idle(e + CPIL * PRTW + 1, e + CPIL * PRTW + 8);
    pmt_hold_drop(2);
    wait_until(e + CPIL * PRTW + 9);

    // trigger held high for 100 cycles: one CPI only
    pmt_rise(e);
    push_cpi(e, 0, CPIL * PRTW);
    push_idle(e + CPIL * PRTW + 1, e + 110);
    pmt_hold_drop(100);
    wait_until(e + 111);

    // extra triggers during RUN are ignored
    pmt_rise(e);
    push_cpi(e, 0, CPIL * PRTW);
    push_idle(e + CPIL * PRTW + 1, e + CPIL * PRTW + 8);
    pmt_hold_drop(2);
    wait_until(e + 5);
    short_pulse();
    wait_until(e + 20);
    short_pulse();
    wait_until(e + CPIL * PRTW + 9);

    // reset at E+7 aborts the CPI without cpi_done
    pmt_rise(e);
    push_cpi(e, 0, 6);
    push_idle(e + 7, e + 14);
    pmt_hold_drop(2);
    wait_until(e + 6);
    btn = 1'b1;
    @(posedge clk);
    #1;
    btn = 1'b0;
    wait_until(e + 15);

    // fresh trigger after the abort reproduces nominal timing
    pmt_rise(e);
    push_cpi(e, 0, CPIL * PRTW);
    push_idle(e + CPIL * PRTW + 1, e + CPIL * PRTW + 8);
    pmt_hold_drop(2);
    wait_until(e + CPIL * PRTW + 9);

    // back-to-back: edge on the final RUN cycle chains the next CPI
    pmt_rise(e);
    push_cpi(e, 0, CPIL * PRTW - 1);
    push_vec(e + CPIL * PRTW, {3'b111, 8'd0, rst_sw(0)}, {3'b111, 8'd0, rst_sw(1)});
    push_cpi(e + CPIL * PRTW, 1, CPIL * PRTW);
    push_idle(e + 2 * CPIL * PRTW + 1, e + 2 * CPIL * PRTW + 8);
    pmt_hold_drop(2);
    wait_until(e + CPIL * PRTW - 3);
    short_pulse();
    wait_until(e + 2 * CPIL * PRTW + 9);

    // every queued expectation must have been consumed
    repeat (4) @(posedge clk);
    #1;
    check_eq("scoreboard drained", W'(exp_cyc_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prt_switch_seq.md
Name: prt_switch_seq

Overview:
Parametrised successor to the single-channel radar PRT switch timer. Waits for a synchronised rising edge on the PMT trigger, then runs exactly CPILENGTH pulse-repetition intervals of PRTWIDTH clocks each. Drives an NCH-bit switch bank once per PRT at a programmable lead (DELAY) before the PRT boundary, in either binary-toggle or one-hot rotate mode. Sits between the PMT front-end input and the RF switch drivers; exposes CPI progress/status to the rest of the sync logic.

Parameters:
PRTWIDTH, 2400, PRT length in sysclk cycles (200 us); range 4..2^CNT_W.
DELAY, 1, switch event occurs DELAY cycles before PRT end; range 0..PRTWIDTH-2.
CPILENGTH, 100, PRTs per CPI; range >= 1.
NCH, 2, switch output channels; range 1..8.
MODE, 0, 0 = binary count (switch[k] toggles every 2^k PRTs); 1 = one-hot rotate (requires NCH >= 2).
PHASE_CLR, 1, 1 = switch bank returns to its reset pattern at CPI end; 0 = phase carries across CPIs.
CNT_W, 12, PRT counter width; elaboration error if 2^CNT_W < PRTWIDTH.
CPI_W, 8, CPI counter width; elaboration error if 2^CPI_W < CPILENGTH.

Ports:
sysclk  in  1  system clock; all logic on its rising edge.
btn  in  [0:0]  btn[0] = reset; synchronous, active-high.
pmt  in  1  asynchronous PMT trigger.
switch  out  NCH  switch bank drive, registered.
cpi  out  CPI_W  index of the current PRT within the CPI.
busy  out  1  high while a CPI is running (state RUN).
prt_start  out  1  one-cycle pulse in the first cycle of every PRT.
cpi_done  out  1  one-cycle pulse in the cycle after the last PRT completes.

Behaviour:
- Reset (btn[0]=1 at an edge) dominates everything. Next cycle: state IDLE, count 0, cpi 0, busy 0, prt_start 0, cpi_done 0, synchroniser flops 0. switch = 0 (MODE 0) or 1 in bit 0 only (MODE 1). Reset mid-CPI aborts it with no cpi_done.
- PMT input: 2-flop synchroniser s1 -> s2, plus s2_d. edge = s2 & ~s2_d. If pmt is first sampled high at edge N, edge is true during the cycle after N+1. Because the flops reset to 0, a pmt held high through reset produces one edge after reset release.
- FSM IDLE: on edge, go to RUN at the next clock (call it E). count=0, cpi=0 and prt_start=1 during the cycle after E. busy is 1 from E onward.
- FSM RUN: count increments each cycle and wraps PRTWIDTH-1 -> 0, giving a period of exactly PRTWIDTH.
  - On each wrap, cpi increments and prt_start pulses.
  - edge is ignored in RUN.
- Switch event: when count == PRTWIDTH-1-DELAY, switch updates at the following clock.
  - MODE 0: switch <= switch + 1 (mod 2^NCH).
  - MODE 1: rotate left by 1.
- CPI end: on the wrap where cpi == CPILENGTH-1:
  - Go to IDLE; cpi <= 0; busy <= 0; cpi_done = 1 for one cycle.
  - If PHASE_CLR=1, switch takes its reset pattern in the same cycle. The switch event of the last PRT has already happened.
- Back-to-back: an edge true in the final RUN cycle (count==PRTWIDTH-1, cpi==CPILENGTH-1) starts the next CPI immediately. FSM stays in RUN; cpi_done and prt_start both pulse; busy stays 1.
- Outputs are all registered; no combinational path from pmt to any output.

Decomposition:
- Package radar_sync_pkg holds:
  - the state enum {IDLE, RUN};
  - MODE constants MODE_BIN = 0, MODE_ONEHOT = 1;
  - the function giving the switch reset pattern per MODE.
- Sub-module pmt_edge_sync: 2-flop synchroniser plus rising-edge detector with synchronous reset. It is reusable for other trigger inputs.

Test Plan:
(Bench uses PRTWIDTH=16, DELAY=2, CPILENGTH=3, NCH=2, MODE=0, PHASE_CLR=1; E = FSM entry edge.)
- Reset: hold btn[0] 3 cycles with pmt=0 -> switch=00, cpi=0, busy=0, prt_start=0, cpi_done=0.
- Nominal CPI: single pmt pulse first sampled at edge 10 -> E=12 and prt_start in the cycle after 12. Switch goes 01 at E+14, 10 at E+30, 11 at E+46. cpi goes 1 at E+16 and 2 at E+32. At E+48: cpi_done pulse, busy=0, cpi=0, switch=00.
- pmt held high for 100 cycles -> exactly one CPI starts; no restart after cpi_done until pmt falls and rises again.
- Extra pmt pulses at E+5 and E+20 -> timing identical to the nominal case.
- Reset at E+7 -> next cycle busy=0, switch=00, cpi=0, no cpi_done. A new pmt pulse then reproduces nominal timing relative to the new E.
- MODE=1 -> switch 01 after reset, 10 at E+14, 01 at E+30, 10 at E+46, 01 at E+48. Separately, with MODE=0, an edge aligned to the last RUN cycle -> cpi_done and prt_start coincide, busy never drops.
